// File: rtl/key_sw_debouncer_pkg.sv
// rtl/key_sw_debouncer_pkg.sv - shared MMIO addresses and debounce default
// Purpose: constants shared by the debouncer, CPU top and data memory so
//          that every agent decodes the I/O window identically.
// Ports:   none (package).
package key_sw_debouncer_pkg;

  localparam logic [31:0] ADDR_KEY      = 32'hF000_0010;
  localparam logic [31:0] ADDR_SW       = 32'hF000_0014;
  localparam logic [31:0] ADDR_KEYPRESS = 32'hF000_0018;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 30;

endpackage

// File: rtl/key_sw_debouncer_sync_debounce.sv
// rtl/key_sw_debouncer_sync_debounce.sv - two-flop synchronizer plus group debounce counter
// Purpose: synchronizes a vector of raw inputs and accepts a change of the
//          whole vector only after it has differed from the accepted value
//          for DEBOUNCE_CYCLES consecutive cycles.
// Ports:   clk, reset_n     clock, asynchronous active-low reset
//          raw    [WIDTH]   unsynchronized input levels
//          sync   [WIDTH]   synchronized levels (second flop)
//          stable [WIDTH]   debounced levels
//          update           high on the cycle whose edge loads stable
module sync_debounce #(
  parameter int                 WIDTH           = 1,
  parameter logic [WIDTH-1:0]   RESET_VALUE     = '0,
  parameter int                 DEBOUNCE_CYCLES = 30
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] stable,
  output logic             update
);

  // Counter saturates at DEBOUNCE_CYCLES-1, so $clog2 bits always suffice.
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] meta;
  logic [CNT_W-1:0] count;
  logic             differ;

  assign differ = (sync != stable);
  assign update = differ && (count == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta   <= RESET_VALUE;
      sync   <= RESET_VALUE;
      stable <= RESET_VALUE;
      count  <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
      if (update) begin
        stable <= sync;
        count  <= '0;
      end else if (differ) begin
        count  <= count + CNT_W'(1);
      end else begin
        // Any cycle of agreement restarts the qualification window.
        count  <= '0;
      end
    end
  end

endmodule

// File: rtl/key_sw_debouncer.sv
// rtl/key_sw_debouncer.sv - debounced switches/keys with sticky press flags and MMIO read port
// Purpose: debounces slide switches and active-low pushbuttons, records key
//          presses in clear-on-read flags and exposes all three on a
//          combinational memory-mapped read port.
// Config:  KEY_STICKY_EN defined   -> key_press flags and clear-on-read built
//          KEY_STICKY_EN undefined -> key_press tied 0, ADDR_KEYPRESS reads 0
// Ports:   clk, reset_n          clock, asynchronous active-low reset
//          sw_raw  [SW_BITS]     raw switch levels
//          key_raw [KEY_BITS]    raw keys, 0 = pressed
//          rd_en, addr[32]       CPU data-memory read strobe and address
//          sw_stable, key_stable debounced levels
//          key_press [KEY_BITS]  sticky press flags
//          rd_data [32]          MMIO read data
module key_sw_debouncer
  import key_sw_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int SW_BITS         = 10,
  parameter int KEY_BITS        = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [SW_BITS-1:0]  sw_raw,
  input  logic [KEY_BITS-1:0] key_raw,
  input  logic                rd_en,
  input  logic [31:0]         addr,
  output logic [SW_BITS-1:0]  sw_stable,
  output logic [KEY_BITS-1:0] key_stable,
  output logic [KEY_BITS-1:0] key_press,
  output logic [31:0]         rd_data
);

  logic [SW_BITS-1:0]  sw_sync;
  logic [KEY_BITS-1:0] key_sync;
  logic                sw_update;
  logic                key_update;

  sync_debounce #(
    .WIDTH           (SW_BITS),
    .RESET_VALUE     ({SW_BITS{1'b0}}),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sw (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (sw_raw),
    .sync    (sw_sync),
    .stable  (sw_stable),
    .update  (sw_update)
  );

  // Keys idle high, so their pipeline resets to "released" and reset
  // release can never look like a press.
  sync_debounce #(
    .WIDTH           (KEY_BITS),
    .RESET_VALUE     ({KEY_BITS{1'b1}}),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (key_raw),
    .sync    (key_sync),
    .stable  (key_stable),
    .update  (key_update)
  );

`ifdef KEY_STICKY_EN
  logic [KEY_BITS-1:0] press_set;
  logic                rd_clear;
  logic                unused_bits;

  // A press is a stable 1->0 transition, detected on the load edge itself.
  assign press_set   = {KEY_BITS{key_update}} & key_stable & ~key_sync;
  assign rd_clear    = rd_en && (addr == ADDR_KEYPRESS);
  assign unused_bits = ^{sw_sync, sw_update};

  // Clear first, then OR in new presses so a simultaneous set wins per bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_press <= '0;
    end else begin
      key_press <= (rd_clear ? {KEY_BITS{1'b0}} : key_press) | press_set;
    end
  end
`else
  logic unused_bits;

  assign key_press   = '0;
  assign unused_bits = ^{rd_en, key_sync, key_update, sw_sync, sw_update};
`endif

  always_comb begin
    rd_data = '0;
    case (addr)
      ADDR_KEY:      rd_data = 32'(key_stable);
      ADDR_SW:       rd_data = 32'(sw_stable);
`ifdef KEY_STICKY_EN
      ADDR_KEYPRESS: rd_data = 32'(key_press);
`endif
      default:       rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_key_sw_debouncer.sv
// tb/tb_key_sw_debouncer.sv - self-checking bench for key_sw_debouncer
module tb_key_sw_debouncer;
  import key_sw_debouncer_pkg::*;

  localparam int D   = 4;
  localparam int SWB = 10;
  localparam int KB  = 4;
`ifdef KEY_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_n;
  logic [SWB-1:0]  sw_raw;
  logic [KB-1:0]   key_raw;
  logic            rd_en;
  logic [31:0]     addr;
  logic [SWB-1:0]  sw_stable;
  logic [KB-1:0]   key_stable;
  logic [KB-1:0]   key_press;
  logic [31:0]     rd_data;

  always #5 clk = ~clk;

  key_sw_debouncer #(
    .DEBOUNCE_CYCLES (D),
    .SW_BITS         (SWB),
    .KEY_BITS        (KB)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sw_raw     (sw_raw),
    .key_raw    (key_raw),
    .rd_en      (rd_en),
    .addr       (addr),
    .sw_stable  (sw_stable),
    .key_stable (key_stable),
    .key_press  (key_press),
    .rd_data    (rd_data)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: raw input delayed two edges; a group accepts its
  // synchronized value once the last D samples since the previous
  // acceptance all disagreed with the accepted value.
  logic [SWB-1:0] m_sw1, m_sw2, m_sw;
  logic [KB-1:0]  m_k1, m_k2, m_k, m_press;
  bit             sw_hist[$];
  bit             key_hist[$];

  task automatic model_reset();
    m_sw1 = '0; m_sw2 = '0; m_sw = '0;
    m_k1 = '1;  m_k2 = '1;  m_k = '1;
    m_press = '0;
    sw_hist.delete();
    key_hist.delete();
  endtask

  task automatic model_edge(input logic [SWB-1:0] sw_in, input logic [KB-1:0] key_in,
                            input logic rd, input logic [31:0] a);
    logic [KB-1:0] old_k;
    bit take;
    old_k = m_k;
    sw_hist.push_back(m_sw2 != m_sw);
    if (sw_hist.size() > D) void'(sw_hist.pop_front());
    take = (sw_hist.size() == D);
    foreach (sw_hist[i]) if (!sw_hist[i]) take = 1'b0;
    if (take) begin
      m_sw = m_sw2;
      sw_hist.delete();
    end
    key_hist.push_back(m_k2 != m_k);
    if (key_hist.size() > D) void'(key_hist.pop_front());
    take = (key_hist.size() == D);
    foreach (key_hist[i]) if (!key_hist[i]) take = 1'b0;
    if (take) begin
      m_k = m_k2;
      key_hist.delete();
    end
    if (STICKY) begin
      if (rd && a == ADDR_KEYPRESS) m_press = '0;
      m_press = m_press | (old_k & ~m_k);
    end
    m_sw2 = m_sw1; m_sw1 = sw_in;
    m_k2  = m_k1;  m_k1  = key_in;
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (a == ADDR_KEY) return 32'(m_k);
    if (a == ADDR_SW) return 32'(m_sw);
    if (a == ADDR_KEYPRESS) return 32'(m_press);
    return 32'h0;
  endfunction

  task automatic check_outputs(input string tag);
    check_eq({tag, ".sw_stable"},  32'(sw_stable),  32'(m_sw));
    check_eq({tag, ".key_stable"}, 32'(key_stable), 32'(m_k));
    check_eq({tag, ".key_press"},  32'(key_press),  32'(m_press));
    check_eq({tag, ".rd_data"},    rd_data,         model_rd(addr));
  endtask

  // Called at a falling edge: drive, compare, take one rising edge, return
  // at the next falling edge.
  task automatic step(input string tag, input logic [SWB-1:0] sw, input logic [KB-1:0] key,
                      input logic rd, input logic [31:0] a);
    sw_raw = sw; key_raw = key; rd_en = rd; addr = a;
    #1;
    check_outputs(tag);
    @(posedge clk);
    model_edge(sw, key, rd, a);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [SWB-1:0] rs;
    logic [KB-1:0]  rk;
    logic [31:0]    ra;
    int sel;

    reset_n = 1'b0; sw_raw = '0; key_raw = '1; rd_en = 1'b0; addr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Reset state
    addr = ADDR_KEY;
    #1;
    check_eq("rst.sw_stable",  32'(sw_stable),  32'h0);
    check_eq("rst.key_stable", 32'(key_stable), 32'hF);
    check_eq("rst.key_press",  32'(key_press),  32'h0);
    check_eq("rst.rd_key",     rd_data,         32'h0000_000F);

    // Latency: 2 + D edges
    repeat (5) step("lat", 10'h2A5, 4'hF, 1'b0, ADDR_SW);
    check_eq("lat.edge5", 32'(sw_stable), 32'h0);
    step("lat", 10'h2A5, 4'hF, 1'b0, ADDR_SW);
    check_eq("lat.edge6", 32'(sw_stable), 32'h2A5);

    // Glitch shorter than D cycles
    repeat (3) step("glitch", 10'h2A5, 4'hD, 1'b0, ADDR_KEY);
    repeat (8) step("glitch", 10'h2A5, 4'hF, 1'b0, ADDR_KEY);
    check_eq("glitch.key_stable", 32'(key_stable), 32'hF);
    check_eq("glitch.key_press",  32'(key_press),  32'h0);

    // Sticky flag and clear-on-read
    repeat (6) step("sticky", 10'h2A5, 4'hE, 1'b0, ADDR_KEYPRESS);
    addr = ADDR_KEYPRESS; #1;
    check_eq("sticky.key_press", 32'(key_press), STICKY ? 32'h1 : 32'h0);
    check_eq("sticky.rd_data",   rd_data,        STICKY ? 32'h1 : 32'h0);
    step("sticky_rd", 10'h2A5, 4'hE, 1'b1, ADDR_KEYPRESS);
    rd_en = 1'b0; #1;
    check_eq("sticky.cleared", 32'(key_press), 32'h0);
    step("sticky_rd2", 10'h2A5, 4'hE, 1'b1, ADDR_KEYPRESS);
    rd_en = 1'b1; #1;
    check_eq("sticky.reread", rd_data, 32'h0);

    // Simultaneous set (key2) and clear-on-read while key_press=0x1
    repeat (8) step("rel", 10'h2A5, 4'hF, 1'b0, ADDR_KEY);
    repeat (6) step("repress", 10'h2A5, 4'hE, 1'b0, ADDR_KEY);
    #1;
    check_eq("simul.pre", 32'(key_press), STICKY ? 32'h1 : 32'h0);
    repeat (5) step("simul", 10'h2A5, 4'hA, 1'b0, ADDR_KEY);
    step("simul_rd", 10'h2A5, 4'hA, 1'b1, ADDR_KEYPRESS);
    rd_en = 1'b0; #1;
    check_eq("simul.key_stable", 32'(key_stable), 32'hA);
    check_eq("simul.key_press",  32'(key_press),  STICKY ? 32'h4 : 32'h0);

    // Mid-count reset
    repeat (3) step("midcnt", 10'h155, 4'hF, 1'b0, ADDR_SW);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("mid.rst_sw",    32'(sw_stable),  32'h0);
    check_eq("mid.rst_key",   32'(key_stable), 32'hF);
    check_eq("mid.rst_press", 32'(key_press),  32'h0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) step("mid", 10'h155, 4'hF, 1'b0, ADDR_SW);
    check_eq("mid.edge5", 32'(sw_stable), 32'h0);
    step("mid", 10'h155, 4'hF, 1'b0, ADDR_SW);
    check_eq("mid.edge6",  32'(sw_stable), 32'h155);
    check_eq("mid.nopress", 32'(key_press), 32'h0);

    // Randomized phase: inputs change rarely so changes both settle and glitch
    rs = 10'h155; rk = 4'hF;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 5) == 0) rs = rs ^ 10'($urandom_range(1, 1023));
      if ($urandom_range(0, 4) == 0) rk = rk ^ 4'($urandom_range(1, 15));
      sel = $urandom_range(0, 3);
      case (sel)
        0: ra = ADDR_KEY;
        1: ra = ADDR_SW;
        2: ra = ADDR_KEYPRESS;
        default: ra = $urandom;
      endcase
      step("rand", rs, rk, ($urandom_range(0, 3) == 0), ra);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
